// File: rtl/imm_encoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_encoder_pipe
//  Purpose  : Packs a 32-bit immediate into RV32 instruction bit positions
//             (I/S/B/U/J) over a base instruction word. Two-stage valid/ready
//             pipeline with range checking and a saturating error counter.
//  Revision : 1.0 - initial release
// ============================================================================
module imm_encoder_pipe #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [31:0]          BASE_INSTR,
    input  logic [2:0]           IMMEDIATE_TYPE,
    input  logic [31:0]          IMMEDIATE_VALUE,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [31:0]          INSTRUCTION,
    output logic                 OUT_ERROR,
    output logic [ERR_CNT_W-1:0] ERR_COUNT
);

    localparam logic [2:0] c_TYPE_I = 3'b000;
    localparam logic [2:0] c_TYPE_S = 3'b001;
    localparam logic [2:0] c_TYPE_J = 3'b010;
    localparam logic [2:0] c_TYPE_U = 3'b011;
    localparam logic [2:0] c_TYPE_B = 3'b100;

    localparam logic [ERR_CNT_W-1:0] c_CNT_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] c_CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    // Stage 1 holding register
    logic        r_s1_valid;
    logic [31:0] r_s1_base;
    logic [2:0]  r_s1_type;
    logic [31:0] r_s1_imm;
    logic        r_s1_err;

    // Stage 2 (output) register
    logic                 r_s2_valid;
    logic [31:0]          r_instr;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic        w_s2_free;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_in_err;
    logic [31:0] w_mask;
    logic [31:0] w_field;
    logic [31:0] w_s2_instr;

    // The output stage can take a new word when empty or draining this cycle.
    assign w_s2_free  = !r_s2_valid | OUT_READY;
    assign IN_READY   = !RESET & (!r_s1_valid | w_s2_free);
    assign w_in_fire  = IN_VALID & IN_READY;
    assign w_out_fire = r_s2_valid & OUT_READY;

    assign OUT_VALID   = r_s2_valid;
    assign INSTRUCTION = r_instr;
    assign OUT_ERROR   = r_err;
    assign ERR_COUNT   = r_err_cnt;

    // Range check: the immediate must survive sign-extension from the field
    // width, with implicit-zero low bits really zero.
    always_comb begin
        w_in_err = 1'b1;
        case (IMMEDIATE_TYPE)
            c_TYPE_I, c_TYPE_S:
                w_in_err = !((&IMMEDIATE_VALUE[31:11]) | ~(|IMMEDIATE_VALUE[31:11]));
            c_TYPE_B:
                w_in_err = !((&IMMEDIATE_VALUE[31:12]) | ~(|IMMEDIATE_VALUE[31:12]))
                           | IMMEDIATE_VALUE[0];
            c_TYPE_J:
                w_in_err = !((&IMMEDIATE_VALUE[31:20]) | ~(|IMMEDIATE_VALUE[31:20]))
                           | IMMEDIATE_VALUE[0];
            c_TYPE_U:
                w_in_err = |IMMEDIATE_VALUE[11:0];
            default:
                w_in_err = 1'b1;
        endcase
    end

    // Field mask and scrambled immediate for the stage-1 word's type; an
    // illegal type has an empty mask so the base word passes through.
    always_comb begin
        w_mask  = 32'h0000_0000;
        w_field = 32'h0000_0000;
        case (r_s1_type)
            c_TYPE_I: begin
                w_mask  = 32'hFFF0_0000;
                w_field = {r_s1_imm[11:0], 20'b0};
            end
            c_TYPE_S: begin
                w_mask  = 32'hFE00_0F80;
                w_field = {r_s1_imm[11:5], 13'b0, r_s1_imm[4:0], 7'b0};
            end
            c_TYPE_B: begin
                w_mask  = 32'hFE00_0F80;
                w_field = {r_s1_imm[12], r_s1_imm[10:5], 13'b0,
                           r_s1_imm[4:1], r_s1_imm[11], 7'b0};
            end
            c_TYPE_U: begin
                w_mask  = 32'hFFFF_F000;
                w_field = {r_s1_imm[31:12], 12'b0};
            end
            c_TYPE_J: begin
                w_mask  = 32'hFFFF_F000;
                w_field = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                           r_s1_imm[19:12], 12'b0};
            end
            default: begin
                w_mask  = 32'h0000_0000;
                w_field = 32'h0000_0000;
            end
        endcase
        // Errored words get their immediate field cleared rather than filled.
        w_s2_instr = (r_s1_base & ~w_mask) | (r_s1_err ? 32'h0000_0000 : w_field);
    end

    // Pipeline advance, output register and saturating error counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1_valid <= 1'b0;
            r_s1_base  <= 32'h0000_0000;
            r_s1_type  <= 3'b000;
            r_s1_imm   <= 32'h0000_0000;
            r_s1_err   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_instr    <= 32'h0000_0000;
            r_err      <= 1'b0;
            r_err_cnt  <= {ERR_CNT_W{1'b0}};
        end else begin
            if (w_in_fire) begin
                r_s1_base <= BASE_INSTR;
                r_s1_type <= IMMEDIATE_TYPE;
                r_s1_imm  <= IMMEDIATE_VALUE;
                r_s1_err  <= w_in_err;
            end
            r_s1_valid <= w_in_fire | (r_s1_valid & !w_s2_free);

            if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_instr <= w_s2_instr;
                    r_err   <= r_s1_err;
                end
            end

            if (w_out_fire && r_err && (r_err_cnt != c_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_encoder_pipe
//  Purpose  : Directed and scoreboard bench for imm_encoder_pipe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imm_encoder_pipe;

    localparam int c_CNT_W = 4;
    localparam int c_CNT_SAT = 15;

    logic               CLK = 1'b0;
    logic               RESET;
    logic               IN_VALID;
    logic               IN_READY;
    logic [31:0]        BASE_INSTR;
    logic [2:0]         IMMEDIATE_TYPE;
    logic [31:0]        IMMEDIATE_VALUE;
    logic               OUT_VALID;
    logic               OUT_READY;
    logic [31:0]        INSTRUCTION;
    logic               OUT_ERROR;
    logic [c_CNT_W-1:0] ERR_COUNT;

    int n_cmp = 0;
    int n_err = 0;

    imm_encoder_pipe #(.ERR_CNT_W(c_CNT_W)) u_dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .IN_VALID        (IN_VALID),
        .IN_READY        (IN_READY),
        .BASE_INSTR      (BASE_INSTR),
        .IMMEDIATE_TYPE  (IMMEDIATE_TYPE),
        .IMMEDIATE_VALUE (IMMEDIATE_VALUE),
        .OUT_VALID       (OUT_VALID),
        .OUT_READY       (OUT_READY),
        .INSTRUCTION     (INSTRUCTION),
        .OUT_ERROR       (OUT_ERROR),
        .ERR_COUNT       (ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] b, input logic [2:0] t, input logic [31:0] v);
        BASE_INSTR      = b;
        IMMEDIATE_TYPE  = t;
        IMMEDIATE_VALUE = v;
        IN_VALID        = 1'b1;
    endtask

    // One isolated word with OUT_READY=1: checks the result and the counter
    // before and after the output transfer.
    task automatic run_one(input string tag, input logic [31:0] b, input logic [2:0] t,
                           input logic [31:0] v, input logic [31:0] exp_instr,
                           input logic exp_err, input int cnt_pre, input int cnt_post);
        OUT_READY = 1'b1;
        drive(b, t, v);
        tick;
        IN_VALID = 1'b0;
        tick;
        chk({tag, "_valid"}, OUT_VALID, 1);
        chk({tag, "_instr"}, INSTRUCTION, exp_instr);
        chk({tag, "_err"}, OUT_ERROR, exp_err);
        chk({tag, "_cnt_pre"}, ERR_COUNT, cnt_pre);
        tick;
        chk({tag, "_cnt_post"}, ERR_COUNT, cnt_post);
    endtask

    // Reference encoder written from the ISA encoding with arithmetic range checks.
    function automatic logic [32:0] model(input logic [31:0] b, input logic [2:0] t,
                                          input logic [31:0] v);
        logic [31:0] r;
        logic        e;
        r = b;
        e = 1'b1;
        case (t)
            3'd0: begin
                e = ($signed(v) < -2048) || ($signed(v) > 2047);
                r[31:20] = e ? 12'h0 : v[11:0];
            end
            3'd1: begin
                e = ($signed(v) < -2048) || ($signed(v) > 2047);
                r[31:25] = e ? 7'h0 : v[11:5];
                r[11:7]  = e ? 5'h0 : v[4:0];
            end
            3'd4: begin
                e = ($signed(v) < -4096) || ($signed(v) > 4095) || v[0];
                r[31]    = e ? 1'b0 : v[12];
                r[30:25] = e ? 6'h0 : v[10:5];
                r[11:8]  = e ? 4'h0 : v[4:1];
                r[7]     = e ? 1'b0 : v[11];
            end
            3'd3: begin
                e = (v[11:0] != 12'h0);
                r[31:12] = e ? 20'h0 : v[31:12];
            end
            3'd2: begin
                e = ($signed(v) < -1048576) || ($signed(v) > 1048575) || v[0];
                r[31]    = e ? 1'b0 : v[20];
                r[30:21] = e ? 10'h0 : v[10:1];
                r[20]    = e ? 1'b0 : v[11];
                r[19:12] = e ? 8'h0 : v[19:12];
            end
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    // ID-stage B-type immediate decode.
    function automatic logic [31:0] dec_b(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    logic [31:0] bp_exp [4];
    logic [32:0] sb [$];

    initial begin
        int k, j, sent, got, cyc, cnt_m;
        logic ifire, ofire;
        logic [31:0] rv;

        RESET = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
        BASE_INSTR = '0; IMMEDIATE_TYPE = '0; IMMEDIATE_VALUE = '0;

        // ---------------- reset state ----------------
        tick; tick;
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_instr", INSTRUCTION, 0);
        chk("rst_err", OUT_ERROR, 0);
        chk("rst_cnt", ERR_COUNT, 0);
        RESET = 1'b0;
        #1;
        chk("post_rst_in_ready", IN_READY, 1);

        // ---------------- I-type latency ----------------
        OUT_READY = 1'b1;
        drive(32'h0000_0013, 3'd0, 32'hFFFF_FFFF);
        tick;
        IN_VALID = 1'b0;
        chk("lat_early", OUT_VALID, 0);
        tick;
        chk("lat_valid", OUT_VALID, 1);
        chk("i_instr", INSTRUCTION, 32'hFFF0_0013);
        chk("i_err", OUT_ERROR, 0);
        tick;
        chk("lat_drain", OUT_VALID, 0);

        // ---------------- S/U/J back-to-back ----------------
        drive(32'h0000_2023, 3'd1, 32'h0000_0008);
        tick;
        drive(32'h0000_00B7, 3'd3, 32'h1234_5000);
        tick;
        chk("s_valid", OUT_VALID, 1);
        chk("s_instr", INSTRUCTION, 32'h0000_2423);
        drive(32'h0000_006F, 3'd2, 32'h0000_0800);
        tick;
        IN_VALID = 1'b0;
        chk("u_valid", OUT_VALID, 1);
        chk("u_instr", INSTRUCTION, 32'h1234_50B7);
        tick;
        chk("j_valid", OUT_VALID, 1);
        chk("j_instr", INSTRUCTION, 32'h0010_006F);
        tick;
        chk("sujj_drain", OUT_VALID, 0);

        // ---------------- B-type with round trip ----------------
        OUT_READY = 1'b1;
        drive(32'h0000_0063, 3'd4, 32'hFFFF_FFFC);
        tick;
        IN_VALID = 1'b0;
        tick;
        chk("b_instr", INSTRUCTION, 32'hFE00_0EE3);
        chk("b_roundtrip", dec_b(INSTRUCTION), 32'hFFFF_FFFC);
        tick;

        // ---------------- errors and boundaries ----------------
        run_one("err_j_odd",  32'h0000_006F, 3'd2, 32'h0000_0003, 32'h0000_006F, 1, 0, 1);
        run_one("err_i_big",  32'h0000_0013, 3'd0, 32'h0000_0800, 32'h0000_0013, 1, 1, 2);
        run_one("err_type7",  32'h1234_5678, 3'd7, 32'h0000_0000, 32'h1234_5678, 1, 2, 3);
        run_one("i_min",      32'h0000_0013, 3'd0, 32'hFFFF_F800, 32'h8000_0013, 0, 3, 3);
        run_one("j_min",      32'h0000_006F, 3'd2, 32'hFFF0_0000, 32'h8000_006F, 0, 3, 3);
        run_one("j_max",      32'h0000_006F, 3'd2, 32'h000F_FFFE, 32'h7FFF_F06F, 0, 3, 3);
        run_one("err_u_low",  32'h0000_00B7, 3'd3, 32'h0000_0123, 32'h0000_00B7, 1, 3, 4);
        run_one("err_b_big",  32'h0000_0063, 3'd4, 32'h0000_1000, 32'h0000_0063, 1, 4, 5);

        // ---------------- backpressure ----------------
        bp_exp[0] = 32'h0010_0013; bp_exp[1] = 32'h0020_0013;
        bp_exp[2] = 32'h0030_0013; bp_exp[3] = 32'h0040_0013;
        k = 0; j = 0;
        for (int c = 0; c < 14; c++) begin
            OUT_READY       = (c >= 6);
            IN_VALID        = (k < 4);
            BASE_INSTR      = 32'h0000_0013;
            IMMEDIATE_TYPE  = 3'd0;
            IMMEDIATE_VALUE = k + 1;
            #1;
            if (c >= 2 && c < 6) begin
                chk("bp_in_ready", IN_READY, 0);
                chk("bp_hold_valid", OUT_VALID, 1);
                chk("bp_hold_instr", INSTRUCTION, 32'h0010_0013);
            end
            if (OUT_VALID && OUT_READY) begin
                if (j < 4) chk("bp_order", INSTRUCTION, bp_exp[j]);
                j++;
            end
            if (IN_VALID && IN_READY) k++;
            if (c == 5) chk("bp_accepts", k, 2);
            tick;
        end
        IN_VALID = 1'b0;
        chk("bp_delivered", j, 4);

        // ---------------- reset mid-flight ----------------
        OUT_READY = 1'b0;
        drive(32'hDEAD_0001, 3'd7, 32'h0);
        tick;
        drive(32'hDEAD_0002, 3'd7, 32'h0);
        tick;
        IN_VALID = 1'b0;
        tick;
        RESET = 1'b1;
        OUT_READY = 1'b1;
        tick;
        chk("mid_rst_valid", OUT_VALID, 0);
        chk("mid_rst_cnt", ERR_COUNT, 0);
        RESET = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("mid_rst_no_old", OUT_VALID, 0);
        end
        chk("mid_rst_cnt_after", ERR_COUNT, 0);

        // ---------------- counter saturation ----------------
        drive(32'h0, 3'd7, 32'h0);
        for (int c = 0; c < 17; c++) tick;
        IN_VALID = 1'b0;
        tick; tick; tick;
        chk("sat_cnt", ERR_COUNT, c_CNT_SAT);
        run_one("sat_hold", 32'hA5A5_A5A5, 3'd6, 32'h0, 32'hA5A5_A5A5, 1, c_CNT_SAT, c_CNT_SAT);

        // ---------------- random backpressure vs scoreboard ----------------
        RESET = 1'b1;
        tick;
        RESET = 1'b0;
        sent = 0; got = 0; cyc = 0; cnt_m = 0;
        while (got < 1000 && cyc < 20000) begin
            rv = $urandom;
            case ($urandom_range(0, 3))
                0: IMMEDIATE_VALUE = rv;
                1: IMMEDIATE_VALUE = {{20{rv[11]}}, rv[11:0]};
                2: IMMEDIATE_VALUE = {{11{rv[20]}}, rv[20:0]};
                default: IMMEDIATE_VALUE = {rv[31:12], 12'h0};
            endcase
            BASE_INSTR     = $urandom;
            IMMEDIATE_TYPE = 3'($urandom_range(0, 7));
            IN_VALID       = (sent < 1000) && ($urandom_range(0, 3) != 0);
            OUT_READY      = ($urandom_range(0, 2) != 0);
            #1;
            ofire = OUT_VALID && OUT_READY;
            ifire = IN_VALID && IN_READY;
            if (OUT_VALID) begin
                if (sb.size() == 0) chk("rnd_spurious", OUT_VALID, 0);
                else chk("rnd_word", {OUT_ERROR, INSTRUCTION}, sb[0]);
            end
            if (ifire) begin
                sb.push_back(model(BASE_INSTR, IMMEDIATE_TYPE, IMMEDIATE_VALUE));
                sent++;
            end
            tick;
            if (ofire && sb.size() > 0) begin
                if (sb[0][32] && cnt_m != c_CNT_SAT) cnt_m++;
                void'(sb.pop_front());
                got++;
            end
            chk("rnd_errcnt", ERR_COUNT, cnt_m);
            cyc++;
        end
        IN_VALID = 1'b0;
        chk("rnd_delivered", got, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
